// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser with
// start/parity/stop checks, and E0/F0 prefix folding into single key events.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       key_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [FC_W-1:0]        r_filt_cnt;
  logic                   r_clk_filt;
  logic                   r_clk_filt_d;
  logic [1:0]             r_state;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_par_bit;
  logic [TO_W-1:0]        r_to_cnt;
  logic [7:0]             r_rx_byte;
  logic                   r_rx_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_brk;
  logic                   r_ext;
  logic [7:0]             r_key_code;
  logic                   r_key_break;
  logic                   r_key_ext;
  logic                   r_key_valid;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_filt_d & ~r_clk_filt;

  // Sync chains idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], kb_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], kb_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_cnt   <= '0;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FC_W'(FILTER_LEN - 1)) begin
        r_clk_filt <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FC_W'(1);
      end
    end
  end

  // r_to_cnt holds cycles elapsed since the last fall (the fall cycle itself is 0),
  // so the frame is abandoned on the cycle that count would reach TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par_bit    <= 1'b0;
      r_to_cnt     <= '0;
      r_rx_byte    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= TO_W'(1);
        case (r_state)
          IDLE: begin
            if (!w_data_s) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end
          DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par_bit <= w_data_s;
            r_state   <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (!(^{r_shift, r_par_bit})) begin
              r_parity_err <= 1'b1;
            end else if (!w_data_s) begin
              r_frame_err <= 1'b1;
            end else begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_shift;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state == IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 2)) begin
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
        r_shift     <= '0;
        r_bit_cnt   <= '0;
        r_to_cnt    <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Prefix folding: E0/F0 only arm flags; the next plain byte emits the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_key_code  <= '0;
      r_key_break <= 1'b0;
      r_key_ext   <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_parity_err || r_frame_err) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (r_rx_valid) begin
        if (r_rx_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_rx_byte == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_key_valid <= 1'b1;
          r_key_code  <= r_rx_byte;
          r_key_break <= r_brk;
          r_key_ext   <= r_ext;
          r_brk       <= 1'b0;
          r_ext       <= 1'b0;
        end
      end
    end
  end

  assign rx_byte    = r_rx_byte;
  assign rx_valid   = r_rx_valid;
  assign key_code   = r_key_code;
  assign key_break  = r_key_break;
  assign key_ext    = r_key_ext;
  assign key_valid  = r_key_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames, prefixes, errors, timeout, glitches, reset.
module tb_ps2_scancode_rx;

  localparam int SYNC = 2;
  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       key_valid;
  logic       parity_err;
  logic       frame_err;

  ps2_scancode_rx #(
    .SYNC_STAGES(SYNC),
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kb_clk(kb_clk),
    .kb_data(kb_data),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .key_code(key_code),
    .key_break(key_break),
    .key_ext(key_ext),
    .key_valid(key_valid),
    .parity_err(parity_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int n_rxv = 0, n_kv = 0, n_pe = 0, n_fe = 0, n_coinc = 0;
  int rxv_cyc = 0, kv_cyc = 0, fe_cyc = 0, fall_cyc = 0;
  int s_rxv, s_kv, s_pe, s_fe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.w_fall) fall_cyc <= cyc;
    if (rx_valid) begin
      n_rxv   <= n_rxv + 1;
      rxv_cyc <= cyc;
    end
    if (key_valid) begin
      n_kv   <= n_kv + 1;
      kv_cyc <= cyc;
    end
    if (parity_err) n_pe <= n_pe + 1;
    if (frame_err) begin
      n_fe   <= n_fe + 1;
      fe_cyc <= cyc;
    end
    if (key_valid && (parity_err || frame_err)) n_coinc <= n_coinc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] kev(input logic [7:0] c, input logic b, input logic e);
    return {22'b0, c, b, e};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_rxv = n_rxv;
    s_kv  = n_kv;
    s_pe  = n_pe;
    s_fe  = n_fe;
  endtask

  // Sends the first nbits of start/data(LSB first)/odd-parity/stop; glitch_bit gets a
  // short kb_clk low pulse during its high phase.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb_data = f[i];
      if (i == glitch_bit) begin
        wait_cyc(10);
        kb_clk = 1'b0;
        wait_cyc(FL - 2);
        kb_clk = 1'b1;
        wait_cyc(HALF - 10 - (FL - 2));
      end else begin
        wait_cyc(HALF);
      end
      kb_clk = 1'b0;
      wait_cyc(HALF);
      kb_clk = 1'b1;
    end
    kb_data = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    wait_cyc(3);
    check("reset_outputs", 32'({rx_byte, rx_valid, key_code, key_break, key_ext,
                                key_valid, parity_err, frame_err}), 32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // plain make code
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    check("t1_rxv_count", n_rxv - s_rxv, 1);
    check("t1_rx_byte", 32'(rx_byte), 32'h1C);
    check("t1_kv_count", n_kv - s_kv, 1);
    check("t1_kv_latency", kv_cyc - rxv_cyc, 1);
    check("t1_key", kev(key_code, key_break, key_ext), kev(8'h1C, 1'b0, 1'b0));
    check("t1_no_err", (n_pe - s_pe) + (n_fe - s_fe), 0);

    // break and extended break
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    check("t2_brk_kv_count", n_kv - s_kv, 1);
    check("t2_brk_key", kev(key_code, key_break, key_ext), kev(8'h1C, 1'b1, 1'b0));
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    send_frame(8'h74, 1'b0, 1'b1, 11, -1);
    check("t2_ext_rxv_count", n_rxv - s_rxv, 3);
    check("t2_ext_kv_count", n_kv - s_kv, 1);
    check("t2_ext_key", kev(key_code, key_break, key_ext), kev(8'h74, 1'b1, 1'b1));

    // parity error drops frame and clears the pending F0
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    check("t3_pe_count", n_pe - s_pe, 1);
    check("t3_rxv_count", n_rxv - s_rxv, 1);
    check("t3_kv_count", n_kv - s_kv, 0);
    check("t3_rx_byte_held", 32'(rx_byte), 32'hF0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    check("t3_after_key", kev(key_code, key_break, key_ext), kev(8'h1C, 1'b0, 1'b0));
    check("t3_after_kv", n_kv - s_kv, 1);

    // timeout after start + 4 data bits
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
    wait_cyc(TO + 20);
    check("t4_fe_count", n_fe - s_fe, 1);
    check("t4_fe_latency", fe_cyc - fall_cyc, TO - 1);
    check("t4_rxv_count", n_rxv - s_rxv, 0);
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 11, -1);
    check("t4_after_key", kev(key_code, key_break, key_ext), kev(8'h5A, 1'b0, 1'b0));
    check("t4_after_kv", n_kv - s_kv, 1);

    // short kb_clk glitches in IDLE and mid-frame
    kb_clk = 1'b0;
    wait_cyc(FL - 2);
    kb_clk = 1'b1;
    wait_cyc(20);
    check("t5_idle_state", 32'(dut.r_state), 32'd0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 3);
    check("t5_glitch_kv", n_kv - s_kv, 1);
    check("t5_glitch_key", kev(key_code, key_break, key_ext), kev(8'h1C, 1'b0, 1'b0));
    check("t5_glitch_no_fe", n_fe - s_fe, 0);

    // bad stop bit drops frame and clears a pending E0
    send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
    check("t5_stop_fe", n_fe - s_fe, 1);
    check("t5_stop_rxv", n_rxv - s_rxv, 0);
    check("t5_stop_pe", n_pe - s_pe, 0);
    send_frame(8'h6B, 1'b0, 1'b1, 11, -1);
    check("t5_stop_after_key", kev(key_code, key_break, key_ext), kev(8'h6B, 1'b0, 1'b0));

    // reset mid-frame after 3 data bits
    send_frame(8'h29, 1'b0, 1'b1, 4, -1);
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", 32'({rx_byte, rx_valid, key_code, key_break, key_ext,
                                   key_valid, parity_err, frame_err}), 32'h0);
    check("t6_reset_state", 32'(dut.r_state), 32'd0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    check("t6_after_kv", n_kv - s_kv, 1);
    check("t6_after_key", kev(key_code, key_break, key_ext), kev(8'h29, 1'b0, 1'b0));

    check("kv_err_coincide", n_coinc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
